// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler. One decrementer is time-multiplexed across
// NCH channel slices, and each channel fires a one-cycle tick every period base ticks.
module tick_scheduler_ch #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_cfg,
    input  logic [CW-1:0] i_cfg_period,
    input  logic          i_clr,
    input  logic          i_svc,
    input  logic          i_fire,
    input  logic [CW-1:0] i_next,
    output logic [CW-1:0] o_period,
    output logic [CW-1:0] o_count,
    output logic          o_tick
);
    logic [CW-1:0] r_period;
    logic [CW-1:0] r_count;
    logic          r_tick;

    // cfg beats clr beats the scan write; a losing scan write also drops its fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period <= '0;
            r_count  <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (i_cfg) begin
                r_period <= i_cfg_period;
                r_count  <= i_cfg_period;
            end else if (i_clr) begin
                r_count <= r_period;
            end else if (i_svc) begin
                r_count <= i_next;
                r_tick  <= i_fire;
            end
        end
    end

    assign o_period = r_period;
    assign o_count  = r_count;
    assign o_tick   = r_tick;
endmodule

module tick_scheduler #(
    parameter int  CLK_FREQ_MHZ = 12,
    parameter int  TICK_US      = 1000,
    parameter int  NCH          = 4,
    parameter int  CW           = 16,
    localparam int CHW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    input  logic [NCH-1:0] en,
    input  logic [NCH-1:0] clr,
    output logic           base_tick,
    output logic [NCH-1:0] tick,
    output logic           scan_busy
);
    localparam int PRE = CLK_FREQ_MHZ * TICK_US;
    localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 r_state, w_state_nxt;
    logic [PW-1:0]          r_pre_cnt;
    logic                   r_base_tick;
    logic                   w_wrap;
    logic [CHW-1:0]         r_idx, w_idx_nxt;
    logic [NCH-1:0][CW-1:0] w_period;
    logic [NCH-1:0][CW-1:0] w_count;
    logic [CW-1:0]          w_cur_per, w_cur_cnt, w_next;
    logic                   w_svc, w_fire;
    logic [NCH-1:0]         w_tick;

    assign w_wrap = (r_pre_cnt == PW'(PRE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre_cnt   <= '0;
            r_base_tick <= 1'b0;
        end else begin
            r_pre_cnt   <= w_wrap ? '0 : r_pre_cnt + PW'(1);
            r_base_tick <= w_wrap;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // SCAN is entered on the same edge that raises base_tick, so channel 0 is
    // serviced during the base_tick cycle and channel k fires k+1 cycles later.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_wrap) begin
                    w_state_nxt = SCAN;
                    w_idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (r_idx == CHW'(NCH - 1)) w_state_nxt = IDLE;
                else                         w_idx_nxt   = r_idx + CHW'(1);
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_cur_per = w_period[r_idx];
    assign w_cur_cnt = w_count[r_idx];
    assign w_svc     = (r_state == SCAN) && (w_cur_per != '0) && en[r_idx];
    assign w_fire    = w_svc && (w_cur_cnt <= CW'(1));
    assign w_next    = w_fire ? w_cur_per : w_cur_cnt - CW'(1);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        tick_scheduler_ch #(.CW(CW)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_cfg        (cfg_we && (cfg_ch == CHW'(k))),
            .i_cfg_period (cfg_period),
            .i_clr        (clr[k]),
            .i_svc        (w_svc && (r_idx == CHW'(k))),
            .i_fire       (w_fire),
            .i_next       (w_next),
            .o_period     (w_period[k]),
            .o_count      (w_count[k]),
            .o_tick       (w_tick[k])
        );
    end

    assign base_tick = r_base_tick;
    assign tick      = w_tick;
    assign scan_busy = (r_state == SCAN);
endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: per-cycle reference model, fire-count vector table,
// hand sequences for en/clr/cfg/reset corners, and a randomized phase.
module tb_tick_scheduler;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int PRE = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic [NCH-1:0] en, clr;
    logic           base_tick, scan_busy;
    logic [NCH-1:0] tick;
    logic           base_tick_d, scan_busy_d;
    logic [NCH-1:0] tick_d;

    always #5 clk = ~clk;

    tick_scheduler #(.CLK_FREQ_MHZ(1), .TICK_US(PRE), .NCH(NCH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .en(en), .clr(clr),
        .base_tick(base_tick), .tick(tick), .scan_busy(scan_busy)
    );

    // Default 12 MHz / 1 ms instance, only used to confirm the real prescale count.
    tick_scheduler u_def (
        .clk(clk), .reset(reset), .cfg_we(1'b0), .cfg_ch(2'd0),
        .cfg_period(16'd0), .en(4'hf), .clr(4'h0),
        .base_tick(base_tick_d), .tick(tick_d), .scan_busy(scan_busy_d)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: m_t is the number of clock edges since reset release.
    // Channel j is serviced in cycle t when t >= PRE and t mod PRE == j.
    int             m_t;
    int             m_per [NCH];
    int             m_cnt [NCH];
    logic [NCH-1:0] e_tick;
    logic           e_base, e_busy;
    int             fire_cnt [NCH];
    int             first_fire [NCH];
    int             last_fire [NCH];

    initial begin
        m_t = 0; e_tick = '0; e_base = 0; e_busy = 0;
        for (int j = 0; j < NCH; j++) begin
            m_per[j] = 0; m_cnt[j] = 0; fire_cnt[j] = 0; first_fire[j] = -1; last_fire[j] = -1;
        end
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_t = 0; e_tick = '0; e_base = 0; e_busy = 0;
                for (int j = 0; j < NCH; j++) begin
                    m_per[j] = 0; m_cnt[j] = 0; fire_cnt[j] = 0; first_fire[j] = -1; last_fire[j] = -1;
                end
            end
            chk("base_tick", base_tick, e_base);
            chk("scan_busy", scan_busy, e_busy);
            chk("tick", tick, e_tick);
            chk("tick_onehot0", 32'($countones(tick) <= 1), 1);
            for (int j = 0; j < NCH; j++) begin
                if (tick[j]) begin
                    fire_cnt[j]++;
                    if (first_fire[j] < 0) first_fire[j] = m_t / PRE;
                    last_fire[j] = m_t / PRE;
                end
            end
            if (reset) begin
                logic [NCH-1:0] nt;
                nt = '0;
                for (int j = 0; j < NCH; j++) begin
                    if (cfg_we && int'(cfg_ch) == j) begin
                        m_per[j] = int'(cfg_period);
                        m_cnt[j] = int'(cfg_period);
                    end else if (clr[j]) begin
                        m_cnt[j] = m_per[j];
                    end else if (m_t >= PRE && (m_t % PRE) == j && m_per[j] != 0 && en[j]) begin
                        if (m_cnt[j] <= 1) begin
                            nt[j] = 1'b1;
                            m_cnt[j] = m_per[j];
                        end else begin
                            m_cnt[j] = m_cnt[j] - 1;
                        end
                    end
                end
                m_t++;
                e_tick = nt;
                e_base = (m_t % PRE) == 0;
                e_busy = (m_t >= PRE) && ((m_t % PRE) < NCH);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        int g;
        g = 0;
        while (m_t < c && g < 50000) begin
            step();
            g++;
        end
        if (m_t < c) chk("run_to_bound", m_t, c);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cfg_we = 1'b0;
        clr = '0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic cfg(input int ch, input int p);
        cfg_we = 1'b1;
        cfg_ch = 2'(ch);
        cfg_period = CW'(p);
        step();
        cfg_we = 1'b0;
    endtask

    typedef struct {
        int             per [NCH];
        logic [NCH-1:0] en;
        int             nb;
        int             exp [NCH];
    } vec_t;

    function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                                input logic [NCH-1:0] e, input int nb,
                                input int c0, input int c1, input int c2, input int c3);
        vec_t v;
        v.per[0] = p0; v.per[1] = p1; v.per[2] = p2; v.per[3] = p3;
        v.en = e;
        v.nb = nb;
        v.exp[0] = c0; v.exp[1] = c1; v.exp[2] = c2; v.exp[3] = c3;
        return v;
    endfunction

    vec_t vt [6];

    initial begin
        int n, busy_n;
        logic tick_or;

        vt[0] = mk(0, 0, 0, 0, 4'b1111,  6,  0,  0, 0, 0);
        vt[1] = mk(0, 0, 3, 0, 4'b0100,  9,  0,  0, 3, 0);
        vt[2] = mk(1, 0, 0, 2, 4'b1111,  8,  8,  0, 0, 4);
        vt[3] = mk(2, 3, 4, 5, 4'b1111, 12,  6,  4, 3, 2);
        vt[4] = mk(2, 3, 4, 5, 4'b0101, 12,  6,  0, 3, 0);
        vt[5] = mk(7, 1, 0, 6, 4'b1111, 13,  1, 13, 0, 2);

        reset = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; en = 4'hf; clr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_base_tick", base_tick, 0);
        chk("rst_scan_busy", scan_busy, 0);
        chk("rst_tick", tick, 0);
        chk("rst_def_base_tick", base_tick_d, 0);
        reset = 1'b1;

        // Default prescale: first base_tick exactly 12000 cycles after release.
        n = 0;
        tick_or = 1'b0;
        for (int i = 1; i <= 13000; i++) begin
            step();
            tick_or |= |tick_d;
            n = i;
            if (base_tick_d) break;
        end
        chk("def_first_base_tick", n, 12000);
        busy_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (scan_busy_d) busy_n++;
            tick_or |= |tick_d;
            step();
        end
        chk("def_scan_busy_len", busy_n, NCH);
        chk("def_tick_idle", tick_or, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            en = vt[v].en;
            for (int j = 0; j < NCH; j++) cfg(j, vt[v].per[j]);
            run_to(vt[v].nb * PRE + NCH + 2);
            for (int j = 0; j < NCH; j++)
                chk($sformatf("vec%0d_fires_ch%0d", v, j), fire_cnt[j], vt[v].exp[j]);
        end

        // en[1] dropped for base ticks 3..6 delays the period-5 fire to tick 9.
        do_reset();
        en = 4'b0010;
        cfg(1, 5);
        run_to(2 * PRE + NCH);
        en = 4'b0000;
        run_to(6 * PRE + NCH);
        en = 4'b0010;
        run_to(9 * PRE - 1);
        chk("en_gap_no_early_fire", fire_cnt[1], 0);
        run_to(9 * PRE + NCH + 1);
        chk("en_gap_first_fire", first_fire[1], 9);
        chk("en_gap_fire_cnt", fire_cnt[1], 1);

        // clr after tick 3 restarts ch0; cfg on the slot of tick 11 beats a due fire.
        do_reset();
        en = 4'b1111;
        cfg(0, 4);
        run_to(3 * PRE + 1);
        clr = 4'b0001;
        step();
        clr = '0;
        run_to(7 * PRE + 2);
        chk("clr_first_fire", first_fire[0], 7);
        run_to(11 * PRE);
        cfg(0, 6);
        run_to(17 * PRE - 1);
        chk("cfg_wins_no_fire", fire_cnt[0], 1);
        run_to(17 * PRE + 2);
        chk("cfg_next_fire_cnt", fire_cnt[0], 2);
        chk("cfg_next_fire_tick", last_fire[0], 17);

        // Reset asserted while tick[0] is high in the middle of a scan.
        do_reset();
        en = 4'b1111;
        cfg(0, 1);
        cfg(1, 1);
        run_to(2 * PRE + 1);
        chk("pre_reset_tick", tick, 4'b0001);
        chk("pre_reset_busy", scan_busy, 1);
        reset = 1'b0;
        #1;
        chk("midscan_rst_tick", tick, 0);
        chk("midscan_rst_busy", scan_busy, 0);
        chk("midscan_rst_base", base_tick, 0);
        step();
        reset = 1'b1;
        run_to(3 * PRE + NCH + 1);
        chk("post_reset_fires", fire_cnt[0] + fire_cnt[1] + fire_cnt[2] + fire_cnt[3], 0);

        // Randomized traffic, checked cycle by cycle by the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cfg_we     = ($urandom_range(7) == 0);
            cfg_ch     = 2'($urandom_range(3));
            cfg_period = CW'($urandom_range(4));
            en         = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'hf;
            clr        = ($urandom_range(15) == 0) ? 4'($urandom_range(15)) : 4'h0;
            step();
        end
        cfg_we = 1'b0;
        clr = '0;
        en = 4'hf;
        repeat (2 * PRE) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Derives a 1 ms base tick from the 12 MHz system clock with a single shared prescaler.
- Time-multiplexes one down-counter datapath across NCH game channels (alien march, player bullet, alien bomb, UFO).
- Emits a one-cycle enable pulse per channel at a programmable period.
- Replaces per-object free-running timers; sits between the game FSM (configures it) and the movement logic (consumes the tick pulses).

Parameters:
- CLK_FREQ_MHZ, 12, system clock frequency in MHz.
- TICK_US, 1000, base tick period in microseconds; prescale count PRE = CLK_FREQ_MHZ*TICK_US (12000).
- NCH, 4, number of channels; must satisfy NCH < PRE.
- CW, 16, width of the period and count registers.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_we  input  1  period write strobe, one cycle.
- cfg_ch  input  $clog2(NCH)  channel index for the write.
- cfg_period  input  CW  new period in base ticks; 0 disables the channel.
- en  input  NCH  per-channel run enable; low freezes the count.
- clr  input  NCH  per-channel synchronous restart.
- base_tick  output  1  one-cycle pulse every PRE clocks.
- tick  output  NCH  per-channel one-cycle fire pulse, registered.
- scan_busy  output  1  high while the scheduler is servicing channels.

Behaviour:
- Reset (reset=0, asynchronous):
  - Prescaler, all period[] and count[] registers, tick, base_tick and scan_busy go to 0.
  - FSM goes to IDLE.
- Prescaler: pre_cnt counts 0..PRE-1 and wraps. base_tick=1 for exactly the cycle after pre_cnt==PRE-1, so the first pulse occurs PRE cycles after reset release.
- FSM IDLE:
  - Stays in IDLE while base_tick=0, with scan_busy=0.
  - In the cycle base_tick=1: idx<=0, go to SCAN.
- FSM SCAN: services channel idx each cycle with the single shared decrementer; scan_busy=1.
  - period[idx]==0 or en[idx]==0: count unchanged, no fire.
  - count[idx]<=1: tick[idx]=1 next cycle; count[idx]<=period[idx].
  - Otherwise: count[idx]<=count[idx]-1.
  - idx==NCH-1: return to IDLE; otherwise idx<=idx+1.
- Latency: channel k's tick rises k+1 cycles after the base_tick pulse. A channel with period P fires once every P base ticks; P=1 fires every base tick.
- tick bits are 0 in every cycle not listed above; at most one tick bit is high per cycle.
- Config write (cfg_we=1): period[cfg_ch]<=cfg_period and count[cfg_ch]<=cfg_period.
  - The first fire is cfg_period base ticks later.
  - Out-of-range cfg_ch (NCH not a power of 2) is ignored.
- clr[k]=1: count[k]<=period[k], with no fire that cycle. Multiple clr bits may be high at once.
- Priority on the same channel in the same cycle: cfg_we > clr > scan update. The losing scan update is discarded, including its fire.
- en dropping mid-scan affects only channels not yet visited.
- count is never written with a value below 0 and never wraps. All arithmetic is unsigned CW-bit.
- Overlapping scans cannot occur, because NCH < PRE. Any reset mid-scan aborts immediately to the reset state.

Test Plan:
- Reset release, no config, all en=1 -> base_tick pulses at cycles 12000, 24000, ...; tick stays 0; scan_busy high 4 cycles after each base_tick.
- cfg ch2 period=3, en=4'b0100 -> tick[2] pulses 3 cycles after every 3rd base_tick (the 3rd, 6th, 9th, ...); no other tick bit is ever high.
- ch0 period=1, ch3 period=2, en=4'b1111 -> tick[0] pulses 1 cycle after every base_tick; tick[3] pulses 4 cycles after every 2nd base_tick; the two pulses are never in the same cycle.
- ch1 period=5: drop en[1] for 4 base ticks after 2 elapsed, then restore -> the first fire lands at base tick 9 instead of 5.
- ch0 period=4: assert clr[0] the cycle after base tick 3, and cfg_we ch0=6 in the same cycle as its scan slot on a later tick -> clr restarts the count to 4 (fire at base tick 7); cfg wins over the scan (no fire that cycle, next fire 6 ticks later).
- Assert reset=0 for 1 cycle in the middle of a scan -> tick, scan_busy and base_tick are 0 immediately; all periods are 0; no tick fires until channels are reconfigured.
